// File: rtl/univ_shift_reg.sv
// Universal shift register: load, logical/arithmetic shifts, rotate, invert,
// hold, plus a multi-cycle rotate-left-by-N with a busy/done handshake.
module univ_shift_reg #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [2:0]       op,
    input  logic [CNT_W-1:0] amt,
    input  logic [WIDTH-1:0] pdata,
    input  logic             sin,
    output logic [WIDTH-1:0] out,
    output logic             sout,
    output logic             busy,
    output logic             done
);

    typedef enum logic [2:0] {
        OP_HOLD = 3'b000,
        OP_LOAD = 3'b001,
        OP_SHL  = 3'b010,
        OP_LSR  = 3'b011,
        OP_ASR  = 3'b100,
        OP_ROL  = 3'b101,
        OP_INV  = 3'b110,
        OP_ROLN = 3'b111
    } op_e;

    // Remaining rotate steps; nonzero only while busy.
    logic [CNT_W-1:0] cnt;

    logic [WIDTH-1:0] shl_val;
    logic [WIDTH-1:0] lsr_val;
    logic [WIDTH-1:0] asr_val;
    logic [WIDTH-1:0] rol_val;
    logic             msb;
    logic             lsb;

    // Single-step results derived from the current register contents.
    always_comb begin
        msb     = out[WIDTH-1];
        lsb     = out[0];
        shl_val = {out[WIDTH-2:0], sin};
        lsr_val = {sin, out[WIDTH-1:1]};
        asr_val = {out[WIDTH-1], out[WIDTH-1:1]};
        rol_val = {out[WIDTH-2:0], out[WIDTH-1]};
    end

    // Register update: reset, multi-step rotate in progress, or accepted op.
    always_ff @(posedge clk) begin
        if (reset) begin
            out  <= '0;
            sout <= 1'b0;
            busy <= 1'b0;
            done <= 1'b0;
            cnt  <= '0;
        end else begin
            done <= 1'b0;
            if (busy) begin
                // A low enable pauses the rotate with everything held.
                if (en) begin
                    out  <= rol_val;
                    sout <= msb;
                    cnt  <= cnt - CNT_W'(1);
                    if (cnt == CNT_W'(1)) begin
                        busy <= 1'b0;
                        done <= 1'b1;
                    end
                end
            end else if (en) begin
                case (op_e'(op))
                    OP_HOLD: begin
                    end
                    OP_LOAD: begin
                        out <= pdata;
                    end
                    OP_SHL: begin
                        out  <= shl_val;
                        sout <= msb;
                    end
                    OP_LSR: begin
                        out  <= lsr_val;
                        sout <= lsb;
                    end
                    OP_ASR: begin
                        out  <= asr_val;
                        sout <= lsb;
                    end
                    OP_ROL: begin
                        out  <= rol_val;
                        sout <= msb;
                    end
                    OP_INV: begin
                        out <= ~out;
                    end
                    OP_ROLN: begin
                        // Zero count completes immediately without going busy.
                        if (amt == '0) begin
                            done <= 1'b1;
                        end else begin
                            busy <= 1'b1;
                            cnt  <= amt;
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

endmodule
